// File: rtl/vdma_read_arbiter.sv
// Round-robin arbiter that shares one AXI read core between NUM channels.
// It grants one burst at a time and steers the read beats to the granted channel.
//
// state  | meaning
// IDLE   | no burst outstanding; pick the next requester round-robin
// REQ    | core_req held for the granted channel until core_resp
// DATA   | burst in flight; axi_rvalid routed to granted channel until core_done
module vdma_read_arbiter #(
  parameter int NUM   = 2,
  parameter int ASIZE = 29,
  parameter int LSIZE = 9
) (
  input  logic                   axi_aclk,
  input  logic                   axi_resetn,
  input  logic [NUM-1:0]         ch_req,
  input  logic [NUM*LSIZE-1:0]   ch_len,
  input  logic [NUM*ASIZE-1:0]   ch_addr,
  output logic [NUM-1:0]         ch_resp,
  output logic [NUM-1:0]         ch_done,
  output logic [NUM-1:0]         ch_wr_en,
  output logic                   core_req,
  output logic [LSIZE-1:0]       core_len,
  output logic [ASIZE-1:0]       core_addr,
  input  logic                   core_resp,
  input  logic                   core_done,
  input  logic                   axi_rvalid,
  output logic [1:0]             grant_id,
  output logic                   busy,
  output logic                   stray_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

  state_t           state;
  logic [1:0]       last;
  logic [1:0]       next_id;
  logic [1:0]       cand;
  logic             found;
  logic [3:0]       req_pad;
  logic [NUM-1:0]   grant_oh;
  logic [LSIZE-1:0] len_arr  [4];
  logic [ASIZE-1:0] addr_arr [4];

  // Pad per-channel fields to four slots so a 2-bit index is always in range.
  for (genvar i = 0; i < 4; i++) begin : g_unpack
    if (i < NUM) begin : g_used
      assign len_arr[i]  = ch_len[i*LSIZE +: LSIZE];
      assign addr_arr[i] = ch_addr[i*ASIZE +: ASIZE];
    end else begin : g_pad
      assign len_arr[i]  = '0;
      assign addr_arr[i] = '0;
    end
  end

  always_comb begin
    req_pad          = '0;
    req_pad[NUM-1:0] = ch_req;
  end

  // Search upward from last+1, wrapping, and take the first requester.
  always_comb begin
    next_id = last;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM; k++) begin
      cand = 2'((int'(last) + k) % NUM);
      if (!found && req_pad[cand]) begin
        next_id = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM; i++) begin
      grant_oh[i] = (grant_id == 2'(i));
    end
  end

  assign core_len  = len_arr[grant_id];
  assign core_addr = addr_arr[grant_id];
  assign ch_resp   = (state == S_REQ  && core_resp)  ? grant_oh : '0;
  assign ch_done   = (state == S_DATA && core_done)  ? grant_oh : '0;
  assign ch_wr_en  = (state == S_DATA && axi_rvalid) ? grant_oh : '0;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state     <= S_IDLE;
      last      <= 2'(NUM - 1);
      grant_id  <= '0;
      core_req  <= 1'b0;
      busy      <= 1'b0;
      stray_err <= 1'b0;
    end else begin
      if (axi_rvalid && state != S_DATA) begin
        stray_err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id <= next_id;
            core_req <= 1'b1;
            busy     <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (core_resp) begin
            core_req <= 1'b0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (core_done) begin
            last  <= grant_id;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          core_req <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdma_read_arbiter.sv
// Bench for vdma_read_arbiter (NUM=3): the bench plays the read core and the
// channels, and predicts grants from a round-robin model.
module tb_vdma_read_arbiter;

  localparam int NUM   = 3;
  localparam int ASIZE = 29;
  localparam int LSIZE = 9;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM-1:0]       ch_req;
  logic [LSIZE-1:0]     lens  [NUM];
  logic [ASIZE-1:0]     addrs [NUM];
  logic [NUM*LSIZE-1:0] ch_len;
  logic [NUM*ASIZE-1:0] ch_addr;
  logic [NUM-1:0]       ch_resp, ch_done, ch_wr_en;
  logic                 core_req;
  logic [LSIZE-1:0]     core_len;
  logic [ASIZE-1:0]     core_addr;
  logic                 core_resp, core_done, axi_rvalid;
  logic [1:0]           grant_id;
  logic                 busy, stray_err;

  int n_tests = 0;
  int n_fail  = 0;
  int m_last  = NUM - 1;
  bit m_stray = 0;

  assign ch_len  = {lens[2], lens[1], lens[0]};
  assign ch_addr = {addrs[2], addrs[1], addrs[0]};

  always #5 clk = ~clk;

  vdma_read_arbiter #(.NUM(NUM), .ASIZE(ASIZE), .LSIZE(LSIZE)) dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .ch_req(ch_req), .ch_len(ch_len), .ch_addr(ch_addr),
    .ch_resp(ch_resp), .ch_done(ch_done), .ch_wr_en(ch_wr_en),
    .core_req(core_req), .core_len(core_len), .core_addr(core_addr),
    .core_resp(core_resp), .core_done(core_done), .axi_rvalid(axi_rvalid),
    .grant_id(grant_id), .busy(busy), .stray_err(stray_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int next_grant(input logic [NUM-1:0] req, input int last);
    for (int k = 1; k <= NUM; k++) begin
      int c;
      c = (last + k) % NUM;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 of an IDLE cycle with ch_req already set; returns at
  // posedge+1 of the IDLE cycle that follows the burst.
  task automatic run_burst(input int beats, input bit tail_done, input bit drop_req,
                           input bit stray_in_req);
    int g, wait_n, sent, guard;
    int cnt [NUM];
    logic [NUM-1:0] oh;
    bit rv, done_now;
    g = next_grant(ch_req, m_last);
    if (g < 0) begin
      chk("model_no_request", 64'(ch_req), 64'h1);
      return;
    end
    oh = NUM'(1) << g;
    foreach (cnt[c]) cnt[c] = 0;

    @(negedge clk);
    chk("idle_core_req", 64'(core_req), 64'h0);
    chk("idle_busy", 64'(busy), 64'h0);
    chk("idle_ch_done", 64'(ch_done), 64'h0);
    next_cycle();

    wait_n = $urandom_range(0, 3);
    for (int k = 0; k <= wait_n; k++) begin
      core_resp  = (k == wait_n);
      axi_rvalid = stray_in_req && (k == 0);
      if (stray_in_req && k == 0) m_stray = 1;
      if (drop_req && k == 0) ch_req[g] = 1'b0;
      @(negedge clk);
      chk("req_core_req", 64'(core_req), 64'h1);
      chk("req_grant_id", 64'(grant_id), 64'(g));
      chk("req_core_len", 64'(core_len), 64'(lens[g]));
      chk("req_core_addr", 64'(core_addr), 64'(addrs[g]));
      chk("req_busy", 64'(busy), 64'h1);
      chk("req_ch_resp", 64'(ch_resp), (k == wait_n) ? 64'(oh) : 64'h0);
      chk("req_ch_wr_en", 64'(ch_wr_en), 64'h0);
      next_cycle();
    end
    core_resp  = 1'b0;
    axi_rvalid = 1'b0;

    sent  = 0;
    guard = 0;
    forever begin
      rv = (sent < beats) ? ($urandom_range(0, 2) != 0) : 1'b0;
      if (tail_done) done_now = rv && (sent == beats - 1);
      else           done_now = (sent == beats);
      guard++;
      if (guard > 8 * beats + 50) done_now = 1'b1;
      axi_rvalid = rv;
      core_done  = done_now;
      core_resp  = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      chk("data_ch_wr_en", 64'(ch_wr_en), rv ? 64'(oh) : 64'h0);
      chk("data_ch_resp", 64'(ch_resp), 64'h0);
      chk("data_ch_done", 64'(ch_done), done_now ? 64'(oh) : 64'h0);
      chk("data_core_req", 64'(core_req), 64'h0);
      chk("data_busy", 64'(busy), 64'h1);
      for (int c = 0; c < NUM; c++) if (ch_wr_en[c]) cnt[c]++;
      if (rv) sent++;
      next_cycle();
      if (done_now) break;
    end
    axi_rvalid = 1'b0;
    core_done  = 1'b0;
    core_resp  = 1'b0;
    m_last = g;

    for (int c = 0; c < NUM; c++)
      chk($sformatf("beats_ch%0d", c), 64'(cnt[c]), (c == g) ? 64'(beats) : 64'h0);
    chk("after_busy", 64'(busy), 64'h0);
    chk("after_ch_done", 64'(ch_done), 64'h0);
    chk("after_stray_err", 64'(stray_err), 64'(m_stray));
  endtask

  initial begin
    int g;
    ch_req = '0; core_resp = 0; core_done = 0; axi_rvalid = 0;
    foreach (lens[c])  lens[c]  = '0;
    foreach (addrs[c]) addrs[c] = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_grant_id", 64'(grant_id), 64'h0);
    chk("rst_core_req", 64'(core_req), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_stray_err", 64'(stray_err), 64'h0);
    chk("rst_pulses", 64'({ch_resp, ch_done, ch_wr_en}), 64'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single long burst on channel 0.
    lens[0] = 9'd200; addrs[0] = 29'h1000; ch_req = 3'b001;
    run_burst(200, 0, 0, 0);

    // Two channels requesting continuously alternate.
    ch_req = 3'b011; lens[1] = 9'd17; addrs[1] = 29'h2000;
    for (int b = 0; b < 4; b++) run_burst(3 + b, 0, 0, 0);

    // Channel 1 idle: after a grant to 0, channel 2 is next.
    ch_req = 3'b001; run_burst(2, 0, 0, 0);
    lens[2] = 9'd33; addrs[2] = 29'h3000; ch_req = 3'b101;
    chk("skip_model", 64'(next_grant(ch_req, m_last)), 64'h2);
    run_burst(4, 0, 0, 0);

    // Final beat coincident with core_done.
    ch_req = 3'b111; run_burst(5, 1, 0, 0);

    // Stray beat while idle.
    ch_req = '0; axi_rvalid = 1'b1;
    @(negedge clk);
    chk("stray_idle_wr_en", 64'(ch_wr_en), 64'h0);
    next_cycle();
    axi_rvalid = 1'b0; m_stray = 1;
    chk("stray_set", 64'(stray_err), 64'h1);
    ch_req = 3'b110; run_burst(3, 0, 0, 0);
    ch_req = 3'b011; run_burst(2, 1, 0, 0);

    // Reset in the middle of DATA.
    ch_req = 3'b010;
    g = next_grant(ch_req, m_last);
    @(negedge clk); next_cycle();
    core_resp = 1'b1;
    @(negedge clk); next_cycle();
    core_resp = 1'b0; axi_rvalid = 1'b1;
    @(negedge clk);
    chk("mid_wr_en", 64'(ch_wr_en), 64'(NUM'(1) << g));
    core_done = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_pulses", 64'({ch_resp, ch_done, ch_wr_en}), 64'h0);
    chk("mid_rst_core_req", 64'(core_req), 64'h0);
    chk("mid_rst_stray", 64'(stray_err), 64'h0);
    next_cycle();
    rst_n = 1'b1; axi_rvalid = 1'b0; core_done = 1'b0;
    m_last = NUM - 1; m_stray = 0;
    ch_req = 3'b111;
    chk("post_rst_model", 64'(next_grant(ch_req, m_last)), 64'h0);
    run_burst(3, 0, 0, 0);

    // Randomized bursts.
    for (int b = 0; b < 30; b++) begin
      ch_req = NUM'($urandom_range(1, 7));
      for (int c = 0; c < NUM; c++) begin
        lens[c]  = LSIZE'($urandom);
        addrs[c] = ASIZE'($urandom);
      end
      run_burst($urandom_range(1, 8), $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/vdma_read_arbiter.md
# vdma_read_arbiter

Shares one AXI read engine (`axi_inf_read_state_core` request interface plus the `axi_rvalid` data stream) between `NUM` read channels. Each channel is a `read_fifo_status_ctrl` / `a_frame_addr` pair. The arbiter grants one burst at a time, round-robin. It muxes the granted channel's length and address onto the core, returns that channel's `resp`/`done` pulses, and steers `axi_rvalid` to the granted channel's stream-FIFO write enable. It sits between the per-channel request logic and the single AXI master port in the `axi_aclk` domain.

## Interface
Parameters:
- `NUM`, default 2: number of requesting channels, legal range 2–4.
- `ASIZE`, default 29: address width.
- `LSIZE`, default 9: burst length width; matches `BURST_LEN_SIZE`.

Ports:
- `axi_aclk`  in  1  the single clock; every register is on the rising edge.
- `axi_resetn`  in  1  asynchronous, active-low reset.
- `ch_req`  in  NUM  per-channel burst request (`burst_req || tail_req`); the channel holds it until `ch_resp`.
- `ch_len`  in  NUM*LSIZE  per-channel `req_len`; channel i occupies bits `[i*LSIZE +: LSIZE]`.
- `ch_addr`  in  NUM*ASIZE  per-channel start address; channel i occupies bits `[i*ASIZE +: ASIZE]`.
- `ch_resp`  out  NUM  one-cycle pulse to the granted channel when the core accepts its request.
- `ch_done`  out  NUM  one-cycle pulse to the granted channel when its burst completes.
- `ch_wr_en`  out  NUM  write enable to channel i's stream FIFO.
- `core_req`  out  1  read request to the core.
- `core_len`  out  LSIZE  granted channel's length.
- `core_addr`  out  ASIZE  granted channel's address.
- `core_resp`  in  1  core accepted the request (`req_resp`).
- `core_done`  in  1  core finished the burst (`req_done`).
- `axi_rvalid`  in  1  AXI read data valid.
- `grant_id`  out  2  index of the current or last granted channel.
- `busy`  out  1  high in the REQ and DATA states.
- `stray_err`  out  1  sticky flag: `axi_rvalid` seen outside the DATA state.

## Operation
- FSM states: IDLE, REQ, DATA.
- **IDLE:** if `ch_req != 0`, select the first set bit searching upward from `(last+1) mod NUM`, wrapping around. Register the result into `grant_id`, then go to REQ. If no request is set, stay in IDLE.
- **REQ:** drive `core_req=1`, `core_len=ch_len[grant_id]`, `core_addr=ch_addr[grant_id]`.
  - On `core_resp`: pulse `ch_resp[grant_id]` in the same cycle (combinational from `core_resp` and state) and go to DATA.
  - Once in REQ, `core_req` is held until `core_resp`, even if `ch_req[grant_id]` drops.
- **DATA:** `core_req=0`; `ch_wr_en[grant_id] = axi_rvalid` (combinational); all other `ch_wr_en` bits stay 0.
  - On `core_done`: pulse `ch_done[grant_id]`, set `last=grant_id`, and go to IDLE.
  - A `core_resp` arriving in DATA is ignored.
- **Data routing:** a beat with `axi_rvalid` in the same cycle as `core_done` is still routed to the granted channel.
- **Stray data:** `axi_rvalid` in IDLE or REQ is dropped (no `ch_wr_en`) and sets `stray_err`. Only reset clears `stray_err`.
- **Outstanding bursts:** exactly one burst is outstanding at a time; the arbiter never issues a second `core_req` before `core_done`.
- **Fairness:** a channel whose request stays asserted is granted within NUM bursts.
- **`core_len` / `core_addr` outside REQ:** muxed from `grant_id`; their value is don't-care.
- **Reset values:**
  - State = IDLE.
  - `last = NUM-1`, so channel 0 wins the first arbitration.
  - `grant_id=0`, `core_req=0`, `busy=0`, `stray_err=0`.
  - All `ch_resp`, `ch_done` and `ch_wr_en` bits = 0.
- **Reset mid-burst:** the arbiter returns to IDLE immediately and pulses nothing. Resetting the core and the channels together is the integrator's responsibility.

## Timing
- `ch_req[i]` rises at edge t while in IDLE → state REQ and `core_req=1` from edge t+1.
- Grant latency from IDLE is 1 cycle.
- `ch_resp` is high for exactly one cycle, coincident with `core_resp`.
- DATA starts at the edge after `core_resp`.
- `ch_done` is coincident with `core_done`. IDLE is entered at the next edge, and the next `core_req` can appear 1 cycle after that: the minimum gap between `core_done` and the next `core_req` is 1 idle cycle.
- `ch_wr_en` has zero latency from `axi_rvalid`, so the FIFO sees the same `axi_rdata` beat.
- `busy` is registered from the state.

## Test plan
- Reset, then `ch_req=2'b01`, `ch_len[0]=200`, `ch_addr[0]=0x1000` → `core_req` rises 1 cycle later with `core_len=200`, `core_addr=0x1000`. `core_resp` → `ch_resp=01` pulse. 200 `axi_rvalid` beats → 200 `ch_wr_en[0]` pulses and 0 on `ch_wr_en[1]`. `core_done` → `ch_done=01`.
- Both channels request continuously (NUM=2) → grants alternate 0,1,0,1 across 4 bursts; `grant_id` matches the channel receiving each `ch_resp`.
- NUM=3, only channels 0 and 2 requesting, last grant=0 → next grant is 2, skipping idle channel 1.
- `axi_rvalid` asserted while in IDLE → no `ch_wr_en`, `stray_err=1`, and it stays 1 through subsequent normal bursts.
- Final beat with `axi_rvalid` and `core_done` in the same cycle → the beat reaches `ch_wr_en[grant]` and `ch_done` pulses once.
- `axi_resetn` low for 1 cycle in DATA → `busy=0` and all pulse outputs 0 immediately. After release, the first grant goes to channel 0.
